// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into STAGES registered ripple slices.
// Macro PIPELINED_ADDER_SAT_EN enables a saturating unsigned result at the output.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    logic adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_d;
        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_d;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic             sub_d;

        logic [WIDTH-1:0] s_n;
        logic             c_n;
        logic             m_n;
        logic             cy;

        logic             v_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             m_q;
        logic             sub_q;

        if (k == 0) begin : g_head
            assign v_d   = in_valid;
            assign a_d   = in1;
            assign b_d   = sub ? ~in2 : in2;
            assign s_d   = '0;
            assign c_d   = sub | c_in;
            assign sub_d = sub;
        end else begin : g_body
            assign v_d   = g_stage[k-1].v_q;
            assign a_d   = g_stage[k-1].a_q;
            assign b_d   = g_stage[k-1].b_q;
            assign s_d   = g_stage[k-1].s_q;
            assign c_d   = g_stage[k-1].c_q;
            assign sub_d = g_stage[k-1].sub_q;
        end

        // Full-adder ripple across this stage's slice; m_n is the carry into the slice MSB
        always_comb begin
            cy  = c_d;
            m_n = c_d;
            s_n = s_d;
            for (int i = 0; i < SW; i++) begin
                m_n = cy;
                s_n[k*SW+i] = a_d[k*SW+i] ^ b_d[k*SW+i] ^ cy;
                cy = (a_d[k*SW+i] & b_d[k*SW+i])
                   | (cy & (a_d[k*SW+i] ^ b_d[k*SW+i]));
            end
            c_n = cy;
`ifdef PIPELINED_ADDER_SAT_EN
            if (k == STAGES - 1) begin
                if (!sub_d && cy) begin
                    s_n = '1;
                end else if (sub_d && !cy) begin
                    s_n = '0;
                end
            end
`endif
        end

        // Stage register: whole pipe holds on stall; data only loads for real items
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                m_q   <= 1'b0;
                sub_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_d;
                if (v_d) begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    s_q   <= s_n;
                    c_q   <= c_n;
                    m_q   <= m_n;
                    sub_q <= sub_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign sum       = g_stage[STAGES-1].s_q;
    assign c_out     = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].m_q ^ g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table, reset/stall sequences and random
// streams scored against an arithmetic reference model.
module tb_pipelined_adder;
    localparam int W  = 32;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;
    int pushed = 0;
    int popped = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         s;
        res_t         r;
    } vec_t;

    res_t exp_q[$];
    vec_t tbl[11];

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t sat_fix(input res_t r, input logic s);
        res_t o = r;
`ifdef PIPELINED_ADDER_SAT_EN
        if (!s && r.c) o.sum = '1;
        else if (s && !r.c) o.sum = '0;
`endif
        return o;
    endfunction

    function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic s);
        res_t r;
        logic [W:0] w;
        if (s) begin
            r.sum = a - b;
            r.c   = (a >= b);
            r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        end else begin
            w     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.sum = w[W-1:0];
            r.c   = w[W];
            r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        end
        return sat_fix(r, s);
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic s,
                                input logic [W-1:0] rs, input logic rc, input logic ro);
        vec_t v;
        v.a = a; v.b = b; v.ci = ci; v.s = s;
        v.r.sum = rs; v.r.c = rc; v.r.ovf = ro;
        v.r = sat_fix(v.r, s);
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input res_t got, input res_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got sum=%h c=%b ovf=%b, want sum=%h c=%b ovf=%b",
                     nm, got.sum, got.c, got.ovf, want.sum, want.c, want.ovf);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    // One clock: sample at negedge, score transfers, return at posedge+1
    task automatic tick();
        @(negedge clk);
        chk_val("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dup: unexpected result sum=%h", sum);
            end else begin
                chk("stream", {sum, c_out, ovf}, exp_q.pop_front());
                popped++;
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(ref_model(in1, in2, c_in, sub));
            pushed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 4 * ST + 20) begin
            tick();
            cyc++;
        end
        chk_val("drain left", exp_q.size(), 0);
        repeat (ST + 2) tick();
    endtask

    task automatic rnd_phase(input int n, input bit full);
        int target = pushed + n;
        int budget = n * 8 + 100;
        int cyc = 0;
        int pop0 = popped;
        while (pushed < target && cyc < budget) begin
            in_valid  = full ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            in1  = rnd_op();
            in2  = rnd_op();
            c_in = 1'($urandom);
            sub  = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk_val("phase accepted", pushed, target);
        if (full) begin
            chk_val("full rate cycles", cyc, n);
            chk_val("full rate outputs", popped - pop0, n - ST);
        end
        drain();
    endtask

    initial begin
        int lat;
        bit bad;

        tbl[0]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[1]  = mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tbl[2]  = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        tbl[3]  = mk(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0);
        tbl[4]  = mk(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0);
        tbl[5]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        tbl[6]  = mk(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        tbl[7]  = mk(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        tbl[8]  = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        tbl[9]  = mk(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0);
        tbl[10] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_val("reset valid", {31'b0, out_valid}, 0);
        chk("reset outputs", {sum, c_out, ovf}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, latency and hold checked
        for (int i = 0; i < 11; i++) begin
            out_ready = 1'b1;
            in1  = tbl[i].a;
            in2  = tbl[i].b;
            c_in = tbl[i].ci;
            sub  = tbl[i].s;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in1 = $urandom;
            in2 = $urandom;
            sub = ~sub;
            lat = 1;
            while (out_valid !== 1'b1 && lat <= 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk_val($sformatf("latency[%0d]", i), lat, ST);
            chk($sformatf("vector[%0d]", i), {sum, c_out, ovf}, tbl[i].r);
            @(posedge clk);
            #1;
            chk_val($sformatf("bubble hold[%0d]", i), {31'b0, out_valid}, 0);
            chk($sformatf("hold data[%0d]", i), {sum, c_out, ovf}, tbl[i].r);
        end

        // Stall with a full output, then reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        in1 = 32'hC000_0000; in2 = 32'h8000_0000; c_in = 1'b0; sub = 1'b0;
        @(posedge clk);
        #1;
        in1 = 32'h1; in2 = 32'h2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (ST) @(posedge clk);
        #1;
        chk_val("stall valid", {31'b0, out_valid}, 1);
        chk("stall data", {sum, c_out, ovf}, sat_fix({32'h4000_0000, 1'b1, 1'b1}, 1'b0));
        chk_val("stall in_ready", {31'b0, in_ready}, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async reset valid", {31'b0, out_valid}, 0);
        chk("async reset outputs", {sum, c_out, ovf}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 1'b0;
        repeat (ST + 4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        chk_val("no stale after reset", {31'b0, bad}, 0);
        @(posedge clk);
        #1;

        rnd_phase(1000, 1'b1);
        rnd_phase(10000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
